// File: rtl/sar_result_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sar_result_fifo
// Description : Captures SAR conversion codes on each EOC rising edge, tags
//               them with a wrapping sequence number and buffers them in a
//               show-ahead FIFO drained through a valid/ready port.
// Revision    : 1.0 - initial release
// ============================================================================
module sar_result_fifo #(
    parameter int BIT_ADC = 6,
    parameter int DEPTH   = 8,
    parameter int TAG_W   = 4
) (
    input  logic                       CLK,
    input  logic                       XRST,
    input  logic                       EN,
    input  logic                       EOC,
    input  logic [BIT_ADC-1:0]         ADC_DATA,
    input  logic                       RD_READY,
    output logic                       RD_VALID,
    output logic [BIT_ADC-1:0]         RD_DATA,
    output logic [TAG_W-1:0]           RD_TAG,
    output logic [$clog2(DEPTH):0]     LEVEL,
    output logic                       OVF,
    input  logic                       OVF_CLR
);

    localparam int c_PTR_W   = $clog2(DEPTH);
    localparam int c_LVL_W   = c_PTR_W + 1;
    localparam int c_ENTRY_W = TAG_W + BIT_ADC;
    localparam logic [c_LVL_W-1:0] c_FULL = c_LVL_W'(DEPTH);

    logic [c_ENTRY_W-1:0] r_mem [DEPTH];
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_LVL_W-1:0]   r_level;
    logic [TAG_W-1:0]     r_tag_cnt;
    logic                 r_eoc_d;
    logic                 r_ovf;

    logic                 w_valid;
    logic                 w_full;
    logic                 w_cap;
    logic                 w_pop;
    logic                 w_push;
    logic                 w_drop;
    logic [c_ENTRY_W-1:0] w_head;

    assign w_valid = (r_level != '0);
    assign w_full  = (r_level == c_FULL);
    assign w_cap   = EN & EOC & ~r_eoc_d;
    assign w_pop   = w_valid & RD_READY;
    // A pop frees the slot at the same edge, so a full FIFO can still accept.
    assign w_push  = w_cap & (~w_full | w_pop);
    assign w_drop  = w_cap & w_full & ~w_pop;

    always_ff @(posedge CLK or negedge XRST) begin
        if (!XRST) begin
            r_eoc_d   <= 1'b0;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_level   <= '0;
            r_tag_cnt <= '0;
            r_ovf     <= 1'b0;
        end else begin
            r_eoc_d <= EOC;
            if (w_cap) begin
                r_tag_cnt <= r_tag_cnt + 1'b1;
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_level <= r_level + 1'b1;
            end else if (w_pop && !w_push) begin
                r_level <= r_level - 1'b1;
            end
            // Overflow set takes priority over a coincident clear.
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (OVF_CLR) begin
                r_ovf <= 1'b0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {r_tag_cnt, ADC_DATA};
        end
    end

    // Storage is not reset, so the head is masked while the FIFO is empty.
    assign w_head   = w_valid ? r_mem[r_rd_ptr] : '0;
    assign RD_VALID = w_valid;
    assign RD_DATA  = w_head[BIT_ADC-1:0];
    assign RD_TAG   = w_head[c_ENTRY_W-1:BIT_ADC];
    assign LEVEL    = r_level;
    assign OVF      = r_ovf;

endmodule
`default_nettype wire
